// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache
// sitting between a core and a request/response backing memory.
module dcache_responder #(
  parameter int LINES  = 16,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic [3:0]        cpu_we,
  input  logic [DWIDTH-1:0] cpu_din,
  output logic [DWIDTH-1:0] cpu_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [DWIDTH-1:0] mem_req_addr,
  output logic [DWIDTH-1:0] mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [DWIDTH-1:0] mem_resp_data
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = DWIDTH - IDXW - 2;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t state_q, state_d;

  logic [TAGW-1:0]   tag_arr  [LINES];
  logic [DWIDTH-1:0] data_arr [LINES];
  logic [LINES-1:0]  valid_q;

  logic [DWIDTH-3:0] req_word;
  logic [DWIDTH-1:0] req_data;
  logic [3:0]        req_mask;

  logic [IDXW-1:0] cpu_idx, req_idx;
  logic [TAGW-1:0] cpu_tag, req_tag;
  logic            is_store, is_read, hit, fill, idle_q;
  logic            unused_addr_lsb;

  assign cpu_idx         = cpu_addr[IDXW+1:2];
  assign cpu_tag         = cpu_addr[DWIDTH-1:IDXW+2];
  assign req_idx         = req_word[IDXW-1:0];
  assign req_tag         = req_word[DWIDTH-3:IDXW];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign idle_q   = (state_q == IDLE);
  assign is_store = |cpu_we;
  assign is_read  = cpu_re & ~is_store;
  assign hit      = valid_q[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign fill     = (state_q == RD_WAIT) && mem_resp_valid;

  function automatic logic [DWIDTH-1:0] merge_lanes(input logic [DWIDTH-1:0] old_word,
                                                    input logic [DWIDTH-1:0] new_word,
                                                    input logic [3:0]        mask);
    logic [DWIDTH-1:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_store)            state_d = WR_REQ;
        else if (cpu_re && !hit) state_d = RD_REQ;
      end
      RD_REQ:  if (mem_req_ready)  state_d = RD_WAIT;
      RD_WAIT: if (mem_resp_valid) state_d = IDLE;
      WR_REQ:  if (mem_req_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, line valid bits and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      cpu_dout <= '0;
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[req_idx] <= 1'b1;
        cpu_dout         <= mem_resp_data;
      end else if (idle_q && is_read && hit) begin
        cpu_dout <= data_arr[cpu_idx];
      end
    end
  end

  // Arrays and the latched request carry no reset; valid_q guards their contents.
  always_ff @(posedge clk) begin
    if (idle_q && (is_store || (cpu_re && !hit))) begin
      req_word <= cpu_addr[DWIDTH-1:2];
      req_data <= cpu_din;
      req_mask <= cpu_we;
    end
    if (idle_q && is_store && hit) begin
      data_arr[cpu_idx] <= merge_lanes(data_arr[cpu_idx], cpu_din, cpu_we);
    end
    if (fill) begin
      data_arr[req_idx] <= mem_resp_data;
      tag_arr[req_idx]  <= req_tag;
    end
  end

  assign stall         = !idle_q;
  assign mem_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_req_rw    = (state_q == WR_REQ);
  assign mem_req_addr  = {req_word, 2'b00};
  assign mem_req_data  = req_data;
  assign mem_req_mask  = req_mask;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a scoreboard of expected memory
// requests and expected read data.
module tb_dcache_responder;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  dcache_responder #(.LINES(16), .DWIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] dout_q[$];
  int          tests = 0;
  int          fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Acts as backing memory from the current negedge until stall drops.
  task automatic serve(input string tag, input int rdelay, input int rsp_dly,
                       input logic [31:0] rdata, input int exp_stall);
    int    cyc = 0;
    int    hs = 0;
    int    wait_rdy = rdelay;
    int    wait_rsp = -1;
    bit    cap = 0;
    mreq_t snap, cur, e;
    while (stall && cyc < 60) begin
      cyc++;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        cur = '{mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask};
        if (!cap) begin
          cap  = 1;
          snap = cur;
          chk({tag, "_queued"}, 32'(mem_q.size() > 0), 32'd1);
          if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            chk({tag, "_rw"}, 32'(cur.rw), 32'(e.rw));
            chk({tag, "_addr"}, cur.addr, e.addr);
            if (e.rw) begin
              chk({tag, "_data"}, cur.data, e.data);
              chk({tag, "_mask"}, 32'(cur.mask), 32'(e.mask));
            end
          end
        end else begin
          chk({tag, "_stable"}, 32'(cur == snap), 32'd1);
        end
        if (wait_rdy == 0) begin
          mem_req_ready = 1'b1;
          hs++;
          if (!mem_req_rw) wait_rsp = rsp_dly;
        end else begin
          wait_rdy--;
        end
      end else if (wait_rsp > 0) begin
        wait_rsp--;
      end else if (wait_rsp == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        wait_rsp       = -1;
      end
      @(negedge clk);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(cyc), 32'(exp_stall));
    chk({tag, "_handshakes"}, 32'(hs), 32'd1);
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] addr, input bit exp_hit,
                          input logic [31:0] exp_data, input int rdelay, input int rsp_dly);
    cpu_addr = addr;
    cpu_re   = 1'b1;
    cpu_we   = 4'b0000;
    dout_q.push_back(exp_data);
    if (!exp_hit) mem_q.push_back('{1'b0, addr, 32'h0, 4'h0});
    @(negedge clk);
    if (exp_hit) begin
      chk({tag, "_hit_stall"}, 32'(stall), 32'd0);
      chk({tag, "_hit_nomem"}, 32'(mem_req_valid), 32'd0);
    end else begin
      chk({tag, "_miss_stall"}, 32'(stall), 32'd1);
      serve(tag, rdelay, rsp_dly, exp_data, 2 + rdelay + rsp_dly);
    end
    cpu_re = 1'b0;
    chk({tag, "_dout"}, cpu_dout, dout_q.pop_front());
  endtask

  task automatic cpu_store(input string tag, input logic [31:0] addr, input logic [3:0] we,
                           input logic [31:0] din, input bit also_re);
    logic [31:0] held;
    held     = cpu_dout;
    cpu_addr = addr;
    cpu_we   = we;
    cpu_din  = din;
    cpu_re   = also_re;
    mem_q.push_back('{1'b1, addr, din, we});
    @(negedge clk);
    chk({tag, "_stall"}, 32'(stall), 32'd1);
    serve(tag, 0, 0, 32'h0, 1);
    cpu_we = 4'b0000;
    cpu_re = 1'b0;
    chk({tag, "_dout_hold"}, cpu_dout, held);
  endtask

  initial begin
    mreq_t e;
    reset = 1'b0;
    cpu_addr = '0; cpu_re = 1'b0; cpu_we = '0; cpu_din = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_memvalid", 32'(mem_req_valid), 32'd0);
    chk("rst_dout", cpu_dout, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    cpu_read("cold_rd", 32'h100, 1'b0, 32'hDEADBEEF, 0, 2);
    cpu_read("re_rd", 32'h100, 1'b1, 32'hDEADBEEF, 0, 0);
    cpu_store("st_hit", 32'h100, 4'b0010, 32'h0000AB00, 1'b0);
    cpu_read("rd_merged", 32'h100, 1'b1, 32'hDEADABEF, 0, 0);
    cpu_read("evict_rd", 32'h140, 1'b0, 32'h12345678, 5, 0);
    cpu_read("refill_rd", 32'h100, 1'b0, 32'hDEADABEF, 0, 1);
    cpu_store("st_miss", 32'h208, 4'b1111, 32'hCAFEF00D, 1'b0);
    cpu_read("noalloc_rd", 32'h208, 1'b0, 32'hCAFEF00D, 0, 0);
    cpu_store("st_prio", 32'h100, 4'b1000, 32'h11000000, 1'b1);
    cpu_read("prio_rd", 32'h100, 1'b1, 32'h11ADABEF, 0, 0);

    // A response arriving while idle must be ignored.
    mem_resp_valid = 1'b1; mem_resp_data = 32'h00000BAD;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_dout", cpu_dout, 32'h11ADABEF);
    chk("stray_memvalid", 32'(mem_req_valid), 32'd0);

    // Abandon a read in RD_WAIT with an asynchronous reset.
    cpu_addr = 32'h304; cpu_re = 1'b1;
    mem_q.push_back('{1'b0, 32'h304, 32'h0, 4'h0});
    @(negedge clk);
    chk("ab_stall", 32'(stall), 32'd1);
    chk("ab_valid", 32'(mem_req_valid), 32'd1);
    e = mem_q.pop_front();
    chk("ab_addr", mem_req_addr, e.addr);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("ab_wait_stall", 32'(stall), 32'd1);
    chk("ab_wait_novalid", 32'(mem_req_valid), 32'd0);
    reset = 1'b0;
    cpu_re = 1'b0;
    #1;
    chk("ab_rst_stall", 32'(stall), 32'd0);
    chk("ab_rst_memvalid", 32'(mem_req_valid), 32'd0);
    chk("ab_rst_dout", cpu_dout, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5A5A5A5A;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stale_stall", 32'(stall), 32'd0);
    chk("stale_dout", cpu_dout, 32'h0);
    cpu_read("post_rst_rd", 32'h100, 1'b0, 32'h11ADABEF, 0, 0);
    cpu_read("post_rst_rd2", 32'h304, 1'b0, 32'h0BADF00D, 0, 1);

    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped one-word lines (power of 2, 2..256).
REQ-002 Parameter DWIDTH, default 32, data and address width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset: 0 = in reset, 1 = run.
REQ-005 cpu_addr  input  DWIDTH  byte address from core; bits [1:0] ignored for array access.
REQ-006 cpu_re  input  1  read request.
REQ-007 cpu_we  input  4  byte-lane write mask; non-zero = store.
REQ-008 cpu_din  input  DWIDTH  store data, already lane-aligned.
REQ-009 cpu_dout  output  DWIDTH  registered read data.
REQ-010 stall  output  1  core shall hold all request inputs while 1.
REQ-011 mem_req_valid  output  1  backing-memory request valid.
REQ-012 mem_req_ready  input  1  backing memory accepts request.
REQ-013 mem_req_rw  output  1  1 = write, 0 = read.
REQ-014 mem_req_addr  output  DWIDTH  word-aligned address ([1:0] = 0).
REQ-015 mem_req_data  output  DWIDTH  write data.
REQ-016 mem_req_mask  output  4  write byte mask.
REQ-017 mem_resp_valid  input  1  read data valid, one cycle per read request.
REQ-018 mem_resp_data  input  DWIDTH  read data.

Function
REQ-019 Index = cpu_addr[log2(LINES)+1:2]; tag = remaining upper bits; one valid bit per line.
REQ-020 FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ; stall = (state != IDLE), decoded from registered state only.
REQ-021 Request sampled only in IDLE; cpu_we != 0 takes priority over cpu_re (store wins when both set).
REQ-022 Read hit in IDLE: cpu_dout <= line data at the sampling edge, state stays IDLE, zero stall cycles, data valid the following cycle.
REQ-023 Read miss in IDLE: latch word address, go to RD_REQ; stall is 1 from the next cycle.
REQ-024 RD_REQ: mem_req_valid=1, mem_req_rw=0; on valid&&ready edge go to RD_WAIT.
REQ-025 RD_WAIT: on mem_resp_valid edge write mem_resp_data into line, set valid and tag, cpu_dout <= mem_resp_data, go to IDLE.
REQ-026 Store in IDLE: write-through, no-write-allocate; on tag hit, update only masked byte lanes of the line at the sampling edge; on miss, array unchanged; go to WR_REQ.
REQ-027 WR_REQ: mem_req_valid=1, mem_req_rw=1, mask/data/addr from latched request; on valid&&ready edge go to IDLE; no response expected.
REQ-028 mem_req_* outputs shall be stable while mem_req_valid=1 and ready=0.
REQ-029 mem_req_valid=0 in IDLE and RD_WAIT.
REQ-030 mem_resp_valid outside RD_WAIT is ignored.
REQ-031 Neither cpu_re nor cpu_we in IDLE: no state change, cpu_dout holds.
REQ-032 cpu_dout changes only on read hit or fill; holds during stores and stall.

Reset
REQ-033 reset=0 asynchronously forces state IDLE, all valid bits 0, cpu_dout 0, stall 0, mem_req_valid 0; tag/data arrays need no reset.
REQ-034 reset asserted mid-transaction abandons it; any later mem_resp_valid is ignored per REQ-030.

Verification
REQ-035 Cold read 0x100, mem ready immediate, resp 2 cycles later data 0xDEADBEEF -> stall 1 for 4 cycles, cpu_dout 0xDEADBEEF when stall falls, one read request at 0x100.
REQ-036 Re-read 0x100 -> no mem request, stall 0, cpu_dout 0xDEADBEEF next cycle.
REQ-037 Store we=4'b0010 din 0x0000AB00 to 0x100 (hit) -> mem write mask 0010 addr 0x100; next read 0x100 returns 0xDEADABEF with no mem read.
REQ-038 Read 0x140 (same index, LINES=16) after 0x100 -> miss, fill evicts; read 0x100 misses again.
REQ-039 mem_req_ready held 0 for 5 cycles in RD_REQ -> request fields stable, stall held, single handshake.
REQ-040 reset low during RD_WAIT, then release -> stall 0, read 0x100 misses, stale mem_resp_valid ignored.
